// File: rtl/cv32e40x_div_seq.sv
// cv32e40x_div_seq
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// One operation is in flight at a time. Operands are sampled only on accept.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i / ready_o   request handshake (ready_o = unit idle)
//   div_operator_i      2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   dividend_i          rs1 value
//   divisor_i           rs2 value
//   kill_i              flush; aborts any in-flight op and drops a same-cycle request
//   valid_o / ready_i   result handshake
//   result_o            quotient or remainder; holds its last value outside DONE
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// ready_o and valid_o are pure functions of the state register, so neither depends
// combinationally on valid_i or ready_i. valid_o and result_o stay stable until accepted.
//
// Optional feature: define CV32E40X_DIV_EARLY_EXIT_EN to finish trivial cases
// (divide by zero, signed overflow, |divisor| > |dividend|) one cycle after accept
// and to skip the leading zero bits of |dividend| in CALC.
//
// The FSM state register state_q is a typed enum for direct observation.

module cv32e40x_div_seq #(
  parameter int WIDTH          = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       div_operator_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int STEPS = WIDTH / ITER_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);

  localparam logic [1:0] DIV_DIV  = 2'b00;
  localparam logic [1:0] DIV_DIVU = 2'b01;
  localparam logic [1:0] DIV_REM  = 2'b10;
  localparam logic [1:0] DIV_REMU = 2'b11;

  if (WIDTH != 32) begin : g_width_chk
    $error("cv32e40x_div_seq: only WIDTH=32 is supported");
  end
  if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2) begin : g_iter_chk
    $error("cv32e40x_div_seq: ITER_PER_CYCLE must be 1 or 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               op_rem_q, op_rem_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;

  // Operand preparation at accept
  logic             signed_op, op_rem, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign signed_op = (div_operator_i == DIV_DIV) || (div_operator_i == DIV_REM);
  assign op_rem    = (div_operator_i == DIV_REM) || (div_operator_i == DIV_REMU);
  assign sign_a    = signed_op & dividend_i[WIDTH-1];
  assign sign_b    = signed_op & divisor_i[WIDTH-1];
  assign abs_a     = sign_a ? -dividend_i : dividend_i;
  assign abs_b     = sign_b ? -divisor_i  : divisor_i;
  assign div_zero  = (divisor_i == '0);

  // Start conditions for CALC, optionally with early exit
  logic             early_exit;
  logic [WIDTH-1:0] early_res;
  logic [CNT_W-1:0] start_cnt;
  logic [WIDTH-1:0] start_quot;

`ifdef CV32E40X_DIV_EARLY_EXIT_EN
  logic overflow;
  assign overflow = signed_op && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);

  always_comb begin
    int msb_bits;
    int steps;
    msb_bits = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_a[i]) msb_bits = i + 1;
    end
    steps = (msb_bits + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    if (steps == 0) steps = 1;
    start_cnt  = CNT_W'(steps - 1);
    // Pre-shift so the significant dividend bits enter the remainder first.
    start_quot = abs_a << (WIDTH - steps * ITER_PER_CYCLE);

    early_exit = div_zero || overflow || (abs_b > abs_a);
    if (op_rem)        early_res = overflow ? '0 : dividend_i;
    else if (div_zero) early_res = '1;
    else if (overflow) early_res = {1'b1, {(WIDTH-1){1'b0}}};
    else               early_res = '0;
  end
`else
  assign early_exit = 1'b0;
  assign early_res  = '0;
  assign start_cnt  = CNT_W'(STEPS - 1);
  assign start_quot = abs_a;
`endif

  // ITER_PER_CYCLE chained restoring steps
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_n, quot_n;

  always_comb begin
    rem_n   = rem_q;
    quot_n  = quot_q;
    shifted = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      shifted = {rem_n, quot_n[WIDTH-1]};
      quot_n  = {quot_n[WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, divisor_q}) begin
        shifted   = shifted - {1'b0, divisor_q};
        quot_n[0] = 1'b1;
      end
      rem_n = shifted[WIDTH-1:0];
    end
  end

  // Sign correction. A zero divisor bypasses quotient negation so the
  // all-ones quotient survives for signed DIV as well.
  logic [WIDTH-1:0] res_mag, res_fin;
  logic             res_neg;

  always_comb begin
    res_mag = op_rem_q ? rem_n : quot_n;
    res_neg = op_rem_q ? neg_rem_q : (neg_quot_q & ~div_zero_q);
    res_fin = res_neg ? -res_mag : res_mag;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    op_rem_d   = op_rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          op_rem_d   = op_rem;
          neg_quot_d = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = div_zero;
          divisor_d  = abs_b;
          rem_d      = '0;
          quot_d     = start_quot;
          cnt_d      = start_cnt;
          if (early_exit) begin
            state_d  = DONE;
            result_d = early_res;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = rem_n;
        quot_d = quot_n;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = res_fin;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      op_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      op_rem_q   <= op_rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
